hist_compute: RTL and testbench

//  Histogram stage feeding the cdf stage. Clears a 64-bin scratch histogram, accepts
//  NUM_PIXELS pixels over a valid/ready stream, and increments bin = pixel MSBs by

---
 rtl/hist_compute.sv | 163 ++++++++++++++++
 tb/tb_hist_compute.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hist_compute.sv
// Histogram stage: clears a 2**BIN_W-bin scratch histogram, bins NUM_PIXELS
// pixels by read-modify-write, then pulses cdf_start.
// Ports:
//   clk, reset (sync, active-low)
//   hist_start_in, pix_valid/pix_data/pix_ready
//   hist_rd_en/addr/data
//   hist_wr_en/addr/data
//   hist_busy, hist_overflow, cdf_start
// Optional feature: `define HIST_SATURATE_EN for saturating counts plus a
// sticky hist_overflow; without it counts wrap and hist_overflow is 0.
module hist_compute #(
    parameter int PIX_W      = 8,
    parameter int BIN_W      = 6,
    parameter int CNT_W      = 16,
    parameter int NUM_PIXELS = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hist_start_in,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             hist_rd_en,
    output logic [BIN_W-1:0] hist_rd_addr,
    input  logic [CNT_W-1:0] hist_rd_data,
    output logic             hist_wr_en,
    output logic [BIN_W-1:0] hist_wr_addr,
    output logic [CNT_W-1:0] hist_wr_data,
    output logic             hist_busy,
    output logic             hist_overflow,
    output logic             cdf_start
);
    localparam int PCW = $clog2(NUM_PIXELS + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, ACCUM, DRAIN, DONE
    } state_t;

    state_t           state, state_nxt;
    logic             start_q;
    logic [BIN_W-1:0] clr_cnt;
    logic [PCW-1:0]   pix_cnt;
    logic             drain_cnt;
    logic             accept, last_pix, begin_img;
    logic [BIN_W-1:0] bin;

    logic             s1_v, s2_v, s3_v;
    logic [BIN_W-1:0] s1_bin, s2_bin, s3_bin;
    logic [CNT_W-1:0] s2_d, s3_d;
    logic [CNT_W-1:0] old_cnt, new_cnt;

    assign bin       = pix_data[PIX_W-1 -: BIN_W];
    assign accept    = (state == ACCUM) && pix_valid;
    assign last_pix  = (pix_cnt == PCW'(NUM_PIXELS - 1));
    assign begin_img = (state == IDLE) && start_q;

    assign hist_rd_en   = accept;
    assign hist_rd_addr = accept ? bin : '0;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        hist_busy = 1'b1;
        cdf_start = 1'b0;
        unique case (state)
            IDLE: begin
                hist_busy = 1'b0;
                if (start_q) state_nxt = CLEAR;
            end
            CLEAR: if (&clr_cnt) state_nxt = ACCUM;
            ACCUM: begin
                pix_ready = 1'b1;
                if (pix_valid && last_pix) state_nxt = DRAIN;
            end
            DRAIN: if (drain_cnt) state_nxt = DONE;
            DONE: begin
                cdf_start = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Masking with busy drops starts seen during an image or in DONE,
    // while a start still held once IDLE is reached gets through.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_q   <= 1'b0;
            clr_cnt   <= '0;
            drain_cnt <= 1'b0;
            pix_cnt   <= '0;
        end else begin
            start_q   <= hist_start_in & ~hist_busy;
            clr_cnt   <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (begin_img)   pix_cnt <= '0;
            else if (accept) pix_cnt <= pix_cnt + 1'b1;
        end
    end

    // s2 is the write issued this cycle; s3 is the write issued in the
    // cycle our read was launched, which the memory did not yet reflect.
    always_comb begin
        if (s2_v && s2_bin == s1_bin)      old_cnt = s2_d;
        else if (s3_v && s3_bin == s1_bin) old_cnt = s3_d;
        else                               old_cnt = hist_rd_data;
    end

`ifdef HIST_SATURATE_EN
    logic [CNT_W:0] sum;
    logic           s2_ovf, ovf_q;

    assign sum           = {1'b0, old_cnt} + 1'b1;
    assign new_cnt       = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign hist_overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_ovf <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s2_ovf <= s1_v & sum[CNT_W];
            if (begin_img)          ovf_q <= 1'b0;
            else if (s2_v & s2_ovf) ovf_q <= 1'b1;
        end
    end
`else
    assign new_cnt       = old_cnt + 1'b1;
    assign hist_overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s3_v   <= 1'b0;
            s1_bin <= '0;
            s2_bin <= '0;
            s3_bin <= '0;
            s2_d   <= '0;
            s3_d   <= '0;
        end else begin
            s1_v   <= accept;
            s1_bin <= bin;
            s2_v   <= s1_v;
            s2_bin <= s1_bin;
            s2_d   <= new_cnt;
            s3_v   <= s2_v;
            s3_bin <= s2_bin;
            s3_d   <= s2_d;
        end
    end

    assign hist_wr_en   = (state == CLEAR) | s2_v;
    assign hist_wr_addr = (state == CLEAR) ? clr_cnt : s2_bin;
    assign hist_wr_data = (state == CLEAR) ? '0 : s2_d;

endmodule

// File: tb/tb_hist_compute.sv
// Bench for hist_compute: random images checked against a per-bin count model.
// Small CNT_W / NUM_PIXELS so wrap and saturation are reachable.
module tb_hist_compute;
    localparam int PIX_W = 8;
    localparam int BIN_W = 6;
    localparam int CNT_W = 8;
    localparam int NPIX  = 300;
    localparam int NB    = 64;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HIST_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             hist_start_in = 1'b0;
    logic             pix_valid = 1'b0;
    logic [PIX_W-1:0] pix_data = '0;
    logic             pix_ready;
    logic             hist_rd_en;
    logic [BIN_W-1:0] hist_rd_addr;
    logic [CNT_W-1:0] hist_rd_data;
    logic             hist_wr_en;
    logic [BIN_W-1:0] hist_wr_addr;
    logic [CNT_W-1:0] hist_wr_data;
    logic             hist_busy;
    logic             hist_overflow;
    logic             cdf_start;

    hist_compute #(
        .PIX_W(PIX_W), .BIN_W(BIN_W), .CNT_W(CNT_W), .NUM_PIXELS(NPIX)
    ) dut (
        .clk(clk), .reset(reset), .hist_start_in(hist_start_in),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr),
        .hist_rd_data(hist_rd_data), .hist_wr_en(hist_wr_en),
        .hist_wr_addr(hist_wr_addr), .hist_wr_data(hist_wr_data),
        .hist_busy(hist_busy), .hist_overflow(hist_overflow),
        .cdf_start(cdf_start)
    );

    always #5 clk = ~clk;

    // Dual-port scratch: registered read returns old data on collision.
    logic [CNT_W-1:0] mem [NB];
    logic             prefill = 1'b0;
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < NB; i++) mem[i] <= '1;
        end else if (hist_wr_en) begin
            mem[hist_wr_addr] <= hist_wr_data;
        end
        if (hist_rd_en) hist_rd_data <= mem[hist_rd_addr];
    end

    int cdf_cnt = 0;
    int busy_cyc = 0;
    bit early_ready = 1'b0;
    bit clr_bad = 1'b0;
    always @(posedge clk) begin
        if (cdf_start) cdf_cnt <= cdf_cnt + 1;
        busy_cyc <= hist_busy ? busy_cyc + 1 : 0;
        if (hist_busy && busy_cyc < NB) begin
            if (pix_ready) early_ready <= 1'b1;
            if (!hist_wr_en || hist_wr_addr != 6'(busy_cyc) ||
                hist_wr_data != '0) clr_bad <= 1'b1;
        end
    end

    int vectors = 0;
    int errors = 0;
    int cnt [NB];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({pix_ready, hist_rd_en, hist_rd_addr, hist_wr_en,
                    hist_wr_addr, hist_wr_data, hist_busy,
                    hist_overflow, cdf_start});
    endfunction

    // mode 0: all 0x00, 1: random, 2: 4,4,4,8 then bins {1,2,5,6}
    task automatic run_image(int mode, int vmode, int abort_at,
                             bit start_mid, string nm);
        logic [7:0] dir [4];
        logic [5:0] bset [4];
        int acc, budget, c0, e;
        bit ovf_e;
        dir = '{8'h04, 8'h04, 8'h04, 8'h08};
        bset = '{6'd1, 6'd2, 6'd5, 6'd6};
        acc = 0;
        budget = 0;
        for (int b = 0; b < NB; b++) cnt[b] = 0;
        c0 = cdf_cnt;
        hist_start_in = 1'b1;
        step();
        hist_start_in = 1'b0;
        while (acc < NPIX && budget < 5000) begin
            if (abort_at > 0 && acc == abort_at) begin
                pix_valid = 1'b0;
                reset = 1'b0;
                step();
                chk({nm, "_rst_outs"}, outs(), 0);
                step();
                step();
                reset = 1'b1;
                repeat (8) step();
                chk({nm, "_rst_no_cdf"}, 64'(cdf_cnt), 64'(c0));
                chk({nm, "_rst_idle"}, 64'(hist_busy), 0);
                return;
            end
            hist_start_in = start_mid && (acc == NPIX / 2);
            pix_valid = (vmode == 0) || ($urandom_range(9) < 6);
            if (mode == 0)      pix_data = 8'h00;
            else if (mode == 1) pix_data = 8'($urandom);
            else if (acc < 4)   pix_data = dir[acc];
            else pix_data = {bset[$urandom_range(3)], 2'($urandom)};
            if (pix_valid && pix_ready) begin
                cnt[pix_data[7:2]]++;
                acc++;
            end
            step();
            budget++;
        end
        pix_valid = 1'b0;
        hist_start_in = 1'b0;
        chk({nm, "_accepts"}, 64'(acc), 64'(NPIX));
        chk({nm, "_ready_drop"}, 64'(pix_ready), 0);
        budget = 0;
        while (cdf_cnt == c0 && budget < 50) begin
            step();
            budget++;
        end
        repeat (4) step();
        chk({nm, "_cdf_once"}, 64'(cdf_cnt), 64'(c0 + 1));
        chk({nm, "_idle"}, 64'(hist_busy), 0);
        ovf_e = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (SAT) e = (cnt[b] > CMAX) ? CMAX : cnt[b];
            else     e = cnt[b] % (CMAX + 1);
            if (SAT && cnt[b] > CMAX) ovf_e = 1'b1;
            chk($sformatf("%s_bin%0d", nm, b), 64'(mem[b]), 64'(e));
        end
        chk({nm, "_overflow"}, 64'(hist_overflow), 64'(ovf_e));
    endtask

    initial begin
        reset = 1'b0;
        prefill = 1'b1;
        step();
        prefill = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), 0);
        reset = 1'b1;
        step();
        chk("idle_ready", 64'(pix_ready), 0);
        run_image(0, 0, 0,   1'b0, "zeros");
        run_image(2, 1, 0,   1'b0, "fwd_toggle");
        run_image(1, 1, 0,   1'b1, "rand_midstart");
        run_image(1, 0, 100, 1'b0, "abort");
        run_image(1, 1, 0,   1'b0, "restart");
        run_image(2, 0, 0,   1'b0, "fwd_b2b");
        chk("no_early_ready", 64'(early_ready), 0);
        chk("clear_seq", 64'(clr_bad), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
